// File: rtl/frame_bank_scheduler.sv
// Purpose: sequences SPI frame transfers and owns the ping-pong video bank selection.
// Latency: start_req 1 cycle after IDLE sees enable; new write_bank visible 1 cycle after the swap tick.
// Backpressure: no new request while enable is low; a late frame holds in READY until the next frame_tick.
module frame_bank_scheduler #(
    parameter int CELL_COUNT = 4800,
    parameter int ADDR_W     = 20,
    parameter int CS_TIMEOUT = 4000000,
    parameter int DROP_W     = 8
) (
    input  logic              CLK_40,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic              chip_select,
    input  logic              wr_strobe,
    output logic              start_req,
    output logic              write_bank,
    output logic              read_bank,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic              bank_swap,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_short,
    output logic [DROP_W-1:0] drop_count
);

    localparam int                TW       = (CS_TIMEOUT > 1) ? $clog2(CS_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] CELL_LIM = ADDR_W'(CELL_COUNT);
    localparam logic [TW-1:0]     CS_LAST  = TW'(CS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_CS,
        S_FILL,
        S_DRAIN,
        S_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     cs_timer;
    logic [ADDR_W-1:0] cell_cnt;
    logic [ADDR_W-1:0] cell_cnt_nxt;
    logic              accept;
    logic              set_timeout;
    logic              set_short;

    // A strobe is only taken while filling and before the frame is full; extras are dropped, never wrapped.
    assign accept       = (state == S_FILL) && wr_strobe && (cell_cnt < CELL_LIM);
    assign cell_cnt_nxt = cell_cnt + {{(ADDR_W-1){1'b0}}, accept};

    assign write_en   = accept;
    assign write_addr = cell_cnt;
    assign busy       = (state != S_IDLE);
    assign read_bank  = ~write_bank;

    // Next-state and per-cycle pulses; the strobe of the current cycle is counted before end-of-frame checks.
    always_comb begin
        state_nxt   = state;
        start_req   = 1'b0;
        bank_swap   = 1'b0;
        set_timeout = 1'b0;
        set_short   = 1'b0;
        case (state)
            S_IDLE: begin
                // chip_select low here is a stale transfer; wait for it to finish before asking again.
                if (enable && chip_select) state_nxt = S_REQ;
            end
            S_REQ: begin
                start_req = 1'b1;
                state_nxt = S_WAIT_CS;
            end
            S_WAIT_CS: begin
                // chip_select falling beats a timeout landing in the same cycle.
                if (!chip_select) begin
                    state_nxt = S_FILL;
                end else if (cs_timer == CS_LAST) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_FILL: begin
                // chip_select was low on entry, so seeing it high here is the rising edge.
                if (chip_select) begin
                    if (cell_cnt_nxt == CELL_LIM) begin
                        state_nxt = S_READY;
                    end else begin
                        set_short = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (cell_cnt_nxt == CELL_LIM) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (chip_select) state_nxt = S_READY;
            end
            S_READY: begin
                if (frame_tick) begin
                    bank_swap = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // chip_select wait timer: zero outside WAIT_CS so each entry starts from 0.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n)                cs_timer <= '0;
        else if (state == S_WAIT_CS) cs_timer <= cs_timer + TW'(1);
        else                         cs_timer <= '0;
    end

    // Cell counter doubles as the write address; cleared as the transfer starts.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n)                                 cell_cnt <= '0;
        else if (state == S_WAIT_CS && !chip_select)  cell_cnt <= '0;
        else                                          cell_cnt <= cell_cnt_nxt;
    end

    // Bank ownership flips only on a completed frame meeting a frame tick.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n)       write_bank <= 1'b0;
        else if (bank_swap) write_bank <= ~write_bank;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            if (set_timeout) err_timeout <= 1'b1;
            if (set_short)   err_short   <= 1'b1;
        end
    end

    // Saturating count of frame ticks that could not swap because no frame was ready.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n)
            drop_count <= '0;
        else if (frame_tick && (state != S_READY) && (drop_count != {DROP_W{1'b1}}))
            drop_count <= drop_count + DROP_W'(1);
    end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: start latency, full/overrun/short frames,
// CS timeout, drop counter saturation and asynchronous reset mid-transfer.
module tb_frame_bank_scheduler;

    localparam int ADDR_W = 20;
    localparam int DROP_W = 8;

    logic              CLK_40;
    logic              reset_n;
    logic              enable;
    logic              frame_tick;
    logic              chip_select;
    logic              wr_strobe;
    logic              start_req;
    logic              write_bank;
    logic              read_bank;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic              bank_swap;
    logic              busy;
    logic              err_timeout;
    logic              err_short;
    logic [DROP_W-1:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    int we_cnt      = 0;
    int swap_cnt    = 0;
    int max_we_addr = 0;
    int max_addr    = 0;
    int inv_err     = 0;
    int we_base;
    int swap_base;
    bit found;

    frame_bank_scheduler #(
        .CELL_COUNT(4800),
        .ADDR_W    (ADDR_W),
        .CS_TIMEOUT(50),
        .DROP_W    (DROP_W)
    ) dut (
        .CLK_40     (CLK_40),
        .reset_n    (reset_n),
        .enable     (enable),
        .frame_tick (frame_tick),
        .chip_select(chip_select),
        .wr_strobe  (wr_strobe),
        .start_req  (start_req),
        .write_bank (write_bank),
        .read_bank  (read_bank),
        .write_en   (write_en),
        .write_addr (write_addr),
        .bank_swap  (bank_swap),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_short  (err_short),
        .drop_count (drop_count)
    );

    initial CLK_40 = 1'b0;
    always #5 CLK_40 = ~CLK_40;

    // Passive observers sampled mid-cycle.
    always @(negedge CLK_40) begin
        if (reset_n) begin
            if (write_en) begin
                we_cnt = we_cnt + 1;
                if (int'(write_addr) > max_we_addr) max_we_addr = int'(write_addr);
            end
            if (int'(write_addr) > max_addr) max_addr = int'(write_addr);
            if (bank_swap) swap_cnt = swap_cnt + 1;
            if (read_bank !== ~write_bank) inv_err = inv_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK_40);
        #1;
    endtask

    // Raise enable and wait (bounded) for the start_req cycle; returns sitting at that cycle's negedge.
    task automatic request(input string tag);
        found  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK_40);
            if (start_req) found = 1'b1;
            else adv();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    // From the start_req cycle: drop chip_select, send n strobes (ticks on strobes 10..10+nticks-1), raise chip_select.
    task automatic fill(input int n, input int nticks);
        adv();
        chip_select = 1'b0;
        enable      = 1'b0;
        @(negedge CLK_40);
        chk("start_req_width", 32'(start_req), 32'd0);
        chk("busy_wait_cs", 32'(busy), 32'd1);
        adv();
        for (int i = 0; i < n; i++) begin
            wr_strobe  = 1'b1;
            frame_tick = (i >= 10) && (i < 10 + nticks);
            adv();
        end
        wr_strobe   = 1'b0;
        frame_tick  = 1'b0;
        chip_select = 1'b1;
        adv();
        @(negedge CLK_40);
    endtask

    // From READY: one frame_tick, check the swap pulse, return one cycle later at negedge.
    task automatic swap_tick(input string tag);
        adv();
        frame_tick = 1'b1;
        @(negedge CLK_40);
        chk(tag, 32'(bank_swap), 32'd1);
        adv();
        frame_tick = 1'b0;
        @(negedge CLK_40);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        frame_tick  = 1'b0;
        chip_select = 1'b1;
        wr_strobe   = 1'b0;
        repeat (3) adv();
        @(negedge CLK_40);
        chk("rst_start_req", 32'(start_req), 32'd0);
        chk("rst_write_bank", 32'(write_bank), 32'd0);
        chk("rst_read_bank", 32'(read_bank), 32'd1);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_addr", 32'(write_addr), 32'd0);
        chk("rst_bank_swap", 32'(bank_swap), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);

        // Start latency: IDLE in the first cycle after release, start_req in the second.
        adv();
        reset_n = 1'b1;
        enable  = 1'b1;
        @(negedge CLK_40);
        chk("start_cycle1", 32'(start_req), 32'd0);
        chk("busy_cycle1", 32'(busy), 32'd0);
        adv();
        @(negedge CLK_40);
        chk("start_cycle2", 32'(start_req), 32'd1);
        chk("busy_cycle2", 32'(busy), 32'd1);

        // Frame 1: exact 4800 cells, three ticks during FILL are drops.
        we_base   = we_cnt;
        swap_base = swap_cnt;
        fill(4800, 3);
        chk("f1_we_pulses", 32'(we_cnt - we_base), 32'd4800);
        chk("f1_max_we_addr", 32'(max_we_addr), 32'd4799);
        chk("f1_write_addr", 32'(write_addr), 32'd4800);
        chk("f1_drop_count", 32'(drop_count), 32'd3);
        chk("f1_busy_ready", 32'(busy), 32'd1);
        chk("f1_bank_before", 32'(write_bank), 32'd0);
        swap_tick("f1_bank_swap");
        chk("f1_write_bank", 32'(write_bank), 32'd1);
        chk("f1_read_bank", 32'(read_bank), 32'd0);
        chk("f1_swap_pulses", 32'(swap_cnt - swap_base), 32'd1);
        chk("f1_swap_one_cycle", 32'(bank_swap), 32'd0);
        chk("f1_idle", 32'(busy), 32'd0);
        chk("f1_drop_unchanged", 32'(drop_count), 32'd3);
        chk("f1_no_err_short", 32'(err_short), 32'd0);

        // Frame 2: overrun by 3 strobes; enable is low while READY and the swap still happens.
        request("f2_request");
        we_base = we_cnt;
        fill(4803, 0);
        chk("f2_we_pulses", 32'(we_cnt - we_base), 32'd4800);
        chk("f2_max_addr", 32'(max_addr), 32'd4800);
        chk("f2_busy_ready", 32'(busy), 32'd1);
        swap_tick("f2_bank_swap");
        chk("f2_write_bank", 32'(write_bank), 32'd0);
        chk("f2_read_bank", 32'(read_bank), 32'd1);

        // Frame 3: short by 4700 cells -> err_short, no swap.
        request("f3_request");
        swap_base = swap_cnt;
        fill(100, 0);
        chk("f3_err_short", 32'(err_short), 32'd1);
        chk("f3_idle", 32'(busy), 32'd0);
        chk("f3_write_addr", 32'(write_addr), 32'd100);
        adv();
        frame_tick = 1'b1;
        adv();
        frame_tick = 1'b0;
        @(negedge CLK_40);
        chk("f3_no_swap", 32'(swap_cnt - swap_base), 32'd0);
        chk("f3_write_bank", 32'(write_bank), 32'd0);
        chk("f3_drop_count", 32'(drop_count), 32'd4);

        // Timeout: chip_select stays high; err_timeout appears after the 50th WAIT_CS cycle.
        request("to_request");
        enable = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            adv();
            @(negedge CLK_40);
        end
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_busy_waiting", 32'(busy), 32'd1);
        adv();
        @(negedge CLK_40);
        chk("to_err_timeout", 32'(err_timeout), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        request("to_rerequest");

        // 300 ticks outside READY saturate the 8-bit drop counter.
        for (int i = 0; i < 300; i++) begin
            adv();
            frame_tick = 1'b1;
        end
        adv();
        frame_tick = 1'b0;
        enable     = 1'b0;
        @(negedge CLK_40);
        chk("drop_saturate", 32'(drop_count), 32'd255);
        repeat (60) adv();
        @(negedge CLK_40);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("sticky_timeout", 32'(err_timeout), 32'd1);

        // Frame 4: full frame so write_bank ends at 1 before the reset test.
        request("f4_request");
        fill(4800, 0);
        swap_tick("f4_bank_swap");
        chk("f4_write_bank", 32'(write_bank), 32'd1);

        // Asynchronous reset in the middle of FILL.
        request("rst_request");
        adv();
        chip_select = 1'b0;
        enable      = 1'b0;
        adv();
        for (int i = 0; i < 10; i++) begin
            wr_strobe = 1'b1;
            adv();
        end
        @(negedge CLK_40);
        chk("mid_write_en", 32'(write_en), 32'd1);
        chk("mid_write_addr", 32'(write_addr), 32'd10);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_write_en", 32'(write_en), 32'd0);
        chk("arst_write_addr", 32'(write_addr), 32'd0);
        chk("arst_write_bank", 32'(write_bank), 32'd0);
        chk("arst_read_bank", 32'(read_bank), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_start_req", 32'(start_req), 32'd0);
        chk("arst_bank_swap", 32'(bank_swap), 32'd0);
        chk("arst_err_timeout", 32'(err_timeout), 32'd0);
        chk("arst_err_short", 32'(err_short), 32'd0);
        chk("arst_drop_count", 32'(drop_count), 32'd0);
        wr_strobe   = 1'b0;
        chip_select = 1'b1;
        repeat (2) adv();

        chk("bank_invariant", 32'(inv_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
